// File: rtl/alu_exec_pkg.sv
// Shared ALUOperation encodings and FSM state codes for the EX-stage ALU.
// The ALU control decoder imports the same constants so encodings cannot drift.
package alu_exec_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/alu_exec_mul.sv
// alu_mul_iter: WIDTH-cycle shift-add multiplier returning the low WIDTH product bits.
// Only instantiated by alu_exec when ALU_EXEC_MUL_EN is defined.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_next;

  // product is the accumulator after this cycle's step, so the final step can be
  // captured by the caller on the same edge that finishes the iteration
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : {WIDTH{1'b0}});
  assign done     = busy_reg && (count_reg == CW'(WIDTH - 1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (start) begin
      busy_reg   <= 1'b1;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// EX-stage ALU with registered result/zero/illegal behind a valid/ready handshake.
// Define ALU_EXEC_MUL_EN to enable the iterative multiply for code 1000.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             zero_reg, zero_next;
  logic             illegal_reg, illegal_next;
  logic [WIDTH-1:0] alu_value;
  logic             alu_illegal;
  logic             accept;

  assign in_ready  = (state_reg == ST_IDLE) || ((state_reg == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == ST_DONE);
  assign result    = result_reg;
  assign zero      = zero_reg;
  assign illegal   = illegal_reg;

  always_comb begin
    alu_value   = '0;
    alu_illegal = 1'b0;
    case (alu_op)
      OP_AND:  alu_value = src_a & src_b;
      OP_OR:   alu_value = src_a | src_b;
      OP_ADD:  alu_value = src_a + src_b;
      OP_SUB:  alu_value = src_a - src_b;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_NOR:  alu_value = ~(src_a | src_b);
`ifdef ALU_EXEC_MUL_EN
      OP_MUL:  alu_value = '0;
`endif
      default: alu_illegal = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  assign mul_start = accept && (alu_op == OP_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  always_comb begin
    state_next   = state_reg;
    result_next  = result_reg;
    zero_next    = zero_reg;
    illegal_next = illegal_reg;
    if (accept) begin
`ifdef ALU_EXEC_MUL_EN
      if (mul_start) begin
        state_next = ST_BUSY;
      end else
`endif
      begin
        state_next   = ST_DONE;
        result_next  = alu_value;
        zero_next    = (alu_value == '0);
        illegal_next = alu_illegal;
      end
    end else if ((state_reg == ST_DONE) && out_ready) begin
      state_next = ST_IDLE;
    end
`ifdef ALU_EXEC_MUL_EN
    if ((state_reg == ST_BUSY) && mul_done) begin
      state_next   = ST_DONE;
      result_next  = mul_product;
      zero_next    = (mul_product == '0);
      illegal_next = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      result_reg  <= '0;
      zero_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      result_reg  <= result_next;
      zero_reg    <= zero_next;
      illegal_reg <= illegal_next;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec (WIDTH 64); MUL checks follow ALU_EXEC_MUL_EN.
module tb_alu_exec;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [63:0] src_a;
  logic [63:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present one op for one edge, then sample #1 after that edge
  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] exp_res, input logic exp_zero,
                         input logic exp_ill);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".zero"}, 64'(zero), 64'(exp_zero));
    chk({tag, ".illegal"}, 64'(illegal), 64'(exp_ill));
    $display("op=%b a=%h b=%h -> result=%h zero=%0b illegal=%0b", alu_op, src_a, src_b,
             result, zero, illegal);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 4'b0010;
    src_a     = 64'd3;
    src_b     = 64'd4;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.zero", 64'(zero), 64'd0);
    chk("rst.illegal", 64'(illegal), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);

    send(4'b0010, 64'd5, 64'd7);      chk_out("add", 64'd12, 1'b0, 1'b0);
    send(4'b0110, 64'd9, 64'd9);      chk_out("sub_eq", 64'd0, 1'b1, 1'b0);
    send(4'b0110, 64'd0, 64'd1);      chk_out("sub_wrap", ONES, 1'b0, 1'b0);
    send(4'b0010, ONES, 64'd1);       chk_out("add_wrap", 64'd0, 1'b1, 1'b0);
    send(4'b0000, 64'hF0, 64'h3C);    chk_out("and", 64'h30, 1'b0, 1'b0);
    send(4'b0001, 64'hF0, 64'h3C);    chk_out("or", 64'hFC, 1'b0, 1'b0);
    send(4'b1100, 64'd0, 64'd0);      chk_out("nor", ONES, 1'b0, 1'b0);
    send(4'b0111, ONES, 64'd1);       chk_out("slt_neg", 64'd1, 1'b0, 1'b0);
    send(4'b0111, 64'd1, ONES);       chk_out("slt_pos", 64'd0, 1'b1, 1'b0);

    @(posedge clk);
    #1;
    chk("drain.out_valid", 64'(out_valid), 64'd0);
    chk("drain.in_ready", 64'(in_ready), 64'd1);

    // backpressure: result held, competing input ignored
    out_ready = 1'b0;
    send(4'b0010, 64'd1, 64'd1);      chk_out("bp_first", 64'd2, 1'b0, 1'b0);
    in_valid = 1'b1;
    alu_op   = 4'b0010;
    src_a    = 64'd9;
    src_b    = 64'd9;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold.result", result, 64'd2);
      chk("bp_hold.valid", 64'(out_valid), 64'd1);
      chk("bp_hold.in_ready", 64'(in_ready), 64'd0);
      $display("bp cycle %0d result=%h in_ready=%0b", i, result, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    send(4'b0010, 64'd3, 64'd4);      chk_out("bp_release", 64'd7, 1'b0, 1'b0);

    send(4'b0011, 64'd5, 64'd6);      chk_out("illegal_0011", 64'd0, 1'b1, 1'b1);

`ifdef ALU_EXEC_MUL_EN
    send(4'b1000, 64'd6, 64'd7);
    for (int i = 0; i < 64; i++) begin
      chk("mul_busy.in_ready", 64'(in_ready), 64'd0);
      chk("mul_busy.valid", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
    end
    chk_out("mul_6x7", 64'd42, 1'b0, 1'b0);

    send(4'b1000, 64'd6, 64'd7);
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      chk("mul_rst.valid", 64'(out_valid), 64'd0);
      chk("mul_rst.in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    $display("mul reset during busy: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    send(4'b0010, 64'd2, 64'd2);      chk_out("post_rst_add", 64'd4, 1'b0, 1'b0);
`else
    send(4'b1000, 64'd6, 64'd7);      chk_out("illegal_mul", 64'd0, 1'b1, 1'b1);
`endif

    send(4'b0010, 64'd10, 64'd20);    chk_out("legal_after", 64'd30, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Sequential execution unit that consumes the 4-bit `ALUOperation` code produced by the ALU control decoder and performs the operation on two register operands. It sits in the EX stage between the operand muxes and the EX/MEM boundary, registering its result and `zero` flag (used for `beq`) behind a valid/ready handshake. An optional iterative multiplier extends the operation set; all other operations complete in one cycle.

## Interface
- `WIDTH`, 64, operand/result width in bits (RV64 datapath).
- `clk`  input  1  clock, all state updates on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  operands and `alu_op` valid this cycle.
- `in_ready`  output  1  unit can accept a new operation this cycle.
- `alu_op`  input  4  ALUOperation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR, 1000 MUL (macro-gated).
- `src_a`  input  WIDTH  first operand.
- `src_b`  input  WIDTH  second operand.
- `out_valid`  output  1  `result`/`zero`/`illegal` valid.
- `out_ready`  input  1  downstream accepts the result.
- `result`  output  WIDTH  operation result.
- `zero`  output  1  1 when `result` == 0.
- `illegal`  output  1  1 when `alu_op` was not a supported code.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state IDLE.
- `in_ready` = (state == IDLE) or (state == DONE and `out_ready`).
- Accept = `in_valid` and `in_ready`. Operands and op are captured on accept; inputs are ignored otherwise.
- Single-cycle op accepted: result computed from captured inputs, registered; next state DONE.
- MUL accepted: next state BUSY; multiplier runs WIDTH cycles; then DONE.
- DONE: `out_valid` = 1; `result`, `zero`, `illegal` stable until `out_ready`. On `out_ready` with no new accept → IDLE; with a new accept → behaves as accept from IDLE (back-to-back).
- Arithmetic: ADD/SUB modulo 2^WIDTH, no overflow flag. SLT: result = 1 if signed `src_a` < signed `src_b`, else 0 (zero-extended). NOR = ~(a|b). MUL: low WIDTH bits of unsigned product.
- Unsupported code: result 0, `zero` 1, `illegal` 1, single-cycle latency.
- `zero` is derived from the registered result, never from the inputs.

## Timing
- Reset (`rst_n` low at edge): state IDLE, `out_valid` 0, `result` 0, `zero` 0, `illegal` 0, multiplier counter 0. `in_ready` is 1 in the first cycle after reset release.
- Single-cycle op: accepted at edge N, `out_valid` high after edge N (cycle N+1).
- MUL: accepted at edge N, `out_valid` high in cycle N+1+WIDTH. `in_ready` is 0 throughout BUSY.
- Back-to-back single-cycle ops with `out_ready` held high: one result per cycle.
- `out_ready` low in DONE: outputs held indefinitely, `in_ready` 0.
- Reset asserted in BUSY or DONE: partial product and pending result are discarded; no `out_valid` after reset.
- `out_ready` is ignored outside DONE.

## Configuration
- `ALU_EXEC_MUL_EN`: defined → code 1000 executes the iterative shift-add multiply (BUSY state, WIDTH-cycle latency). Undefined → 1000 is treated as illegal (result 0, `illegal` 1, one-cycle latency); the BUSY state and multiplier logic are not generated, and the FSM never leaves IDLE/DONE.

## Structure
- Shared definitions file (the team's package equivalent, `alu_defs.vh`): the 4-bit ALUOperation constants (AND, OR, ADD, SUB, SLT, NOR, MUL) and FSM state encodings. The same constants are used by the ALU control decoder so encodings cannot diverge.
- One sub-module: `alu_mul_iter` (start, operands, done, product; WIDTH-cycle shift-add), instantiated only under `ALU_EXEC_MUL_EN`.

## Test plan
- Reset: hold `rst_n` low 3 cycles with `in_valid` 1 → `out_valid` 0, `result` 0, `zero` 0, `illegal` 0; `in_ready` 1 in the first cycle after release.
- ADD/SUB/zero: ADD 5+7 → `result` 12, `zero` 0 after 1 cycle; SUB 9−9 → `result` 0, `zero` 1; SUB 0−1 → 0xFFFF_FFFF_FFFF_FFFF.
- Logic/SLT: AND 0xF0 & 0x3C → 0x30; OR → 0xFC; NOR 0,0 → all ones; SLT −1 vs 1 → 1; SLT 1 vs −1 → 0.
- Backpressure: ADD 1+1 with `out_ready` 0 for 4 cycles → `result` 2 held, `in_ready` 0; `out_ready` 1 with new ADD 3+4 → next cycle `result` 7.
- MUL (macro defined): 6 × 7 → `in_ready` 0 for 64 cycles, then `result` 42; reset asserted at cycle 20 of BUSY → no `out_valid`, state IDLE.
- Illegal: `alu_op` 0011 → `result` 0, `zero` 1, `illegal` 1 after 1 cycle; macro undefined, `alu_op` 1000 → same response.
